// File: rtl/move_key_arbiter.sv
// move_key_arbiter
//   Resolves the four held-key slots of the keyboard report into one movement
//   direction per ball sprite, once per frame. Player 1 is driven by WASD
//   (codes set by the P1_* parameters), player 2 by the arrow keys. Both
//   outputs use the arrow convention: 82 up, 80 left, 81 down, 79 right, 0 none.
//
// Ports
//   Clk                 system clock, all logic on the rising edge
//   Reset               synchronous, active-high reset
//   frame_clk           frame strobe (synchronous to Clk); rising edge starts a scan
//   keycode0..keycode3  held-key slots, 0 = empty
//   p1_keycode          player 1 direction
//   p2_keycode          player 2 direction
//   cmd_valid           one-cycle pulse when p1/p2_keycode have just been updated
//   busy                high while a scan or commit is in progress
module move_key_arbiter #(
    parameter logic [7:0] P1_UP    = 8'd26,
    parameter logic [7:0] P1_LEFT  = 8'd4,
    parameter logic [7:0] P1_DOWN  = 8'd22,
    parameter logic [7:0] P1_RIGHT = 8'd7,
    parameter bit         STICKY   = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    output logic [7:0] p1_keycode,
    output logic [7:0] p2_keycode,
    output logic       cmd_valid,
    output logic       busy
);

    localparam logic [7:0] K_UP    = 8'd82;
    localparam logic [7:0] K_LEFT  = 8'd80;
    localparam logic [7:0] K_DOWN  = 8'd81;
    localparam logic [7:0] K_RIGHT = 8'd79;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t           state, state_nxt;
    logic             fr_q;
    logic             tick;
    logic [3:0][7:0]  shadow;
    logic [1:0]       idx;
    logic [7:0]       cur_key;
    logic [7:0]       p1_code, p2_code;

    // per-player scan results
    logic             p1_found, p2_found;
    logic [7:0]       p1_first, p2_first;
    logic             p1_keep, p2_keep;

    // Player 1 keys are remapped onto the arrow convention; 0 means "not ours".
    function automatic logic [7:0] xlate_p1(input logic [7:0] k);
        logic [7:0] r;
        r = 8'd0;
        if      (k == P1_UP)    r = K_UP;
        else if (k == P1_LEFT)  r = K_LEFT;
        else if (k == P1_DOWN)  r = K_DOWN;
        else if (k == P1_RIGHT) r = K_RIGHT;
        return r;
    endfunction

    function automatic logic [7:0] xlate_p2(input logic [7:0] k);
        logic [7:0] r;
        r = 8'd0;
        if (k == K_UP || k == K_LEFT || k == K_DOWN || k == K_RIGHT)
            r = k;
        return r;
    endfunction

    // fr_q resets high so a frame_clk held high through reset is not a tick
    assign tick    = frame_clk & ~fr_q;
    assign busy    = (state != IDLE);
    assign cur_key = shadow[idx];
    assign p1_code = (cur_key == 8'd0) ? 8'd0 : xlate_p1(cur_key);
    assign p2_code = xlate_p2(cur_key);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SCAN;
            SCAN:    if (idx == 2'd3) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fr_q       <= 1'b1;
            shadow     <= '0;
            idx        <= 2'd0;
            p1_found   <= 1'b0;
            p2_found   <= 1'b0;
            p1_first   <= 8'd0;
            p2_first   <= 8'd0;
            p1_keep    <= 1'b0;
            p2_keep    <= 1'b0;
            p1_keycode <= 8'd0;
            p2_keycode <= 8'd0;
            cmd_valid  <= 1'b0;
        end else begin
            fr_q      <= frame_clk;
            cmd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // ticks outside IDLE are dropped, never queued
                    if (tick) begin
                        shadow   <= {keycode3, keycode2, keycode1, keycode0};
                        idx      <= 2'd0;
                        p1_found <= 1'b0;
                        p2_found <= 1'b0;
                        p1_first <= 8'd0;
                        p2_first <= 8'd0;
                        p1_keep  <= 1'b0;
                        p2_keep  <= 1'b0;
                    end
                end
                SCAN: begin
                    idx <= idx + 2'd1;
                    // sticky match beats first-found, so a held key keeps its
                    // direction even when an opposite key sits in a lower slot
                    if (p1_code != 8'd0) begin
                        if (STICKY && p1_code == p1_keycode) p1_keep <= 1'b1;
                        else if (!p1_found) begin
                            p1_first <= p1_code;
                            p1_found <= 1'b1;
                        end
                    end
                    if (p2_code != 8'd0) begin
                        if (STICKY && p2_code == p2_keycode) p2_keep <= 1'b1;
                        else if (!p2_found) begin
                            p2_first <= p2_code;
                            p2_found <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (!p1_keep) p1_keycode <= p1_found ? p1_first : 8'd0;
                    if (!p2_keep) p2_keycode <= p2_found ? p2_first : 8'd0;
                    cmd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
